// File: rtl/sincn_decim_mc.sv
`default_nettype none
// ============================================================================
// Module   : sincn_decim_mc
// Brief    : Multi-channel sinc1/2/3 decimator; per-channel integrators with
//            one shared, time-multiplexed comb and a saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module sincn_decim_mc #(
    parameter int CHANNELS  = 4,
    parameter int OSR_WIDTH = 8,
    parameter int RES_WIDTH = 1 + 3*OSR_WIDTH,
    parameter int WIDTH     = RES_WIDTH + 1,
    parameter int CH_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clock,
    input  logic                        aclr,
    input  logic [CHANNELS-1:0]         i_sdi,
    input  logic [OSR_WIDTH-1:0]        i_osr,
    input  logic [1:0]                  i_order,
    output logic signed [RES_WIDTH-1:0] o_data,
    output logic [CH_WIDTH-1:0]         o_ch,
    output logic                        o_ovf,
    output logic                        o_valid
);

    localparam logic [OSR_WIDTH-1:0] c_OSR_MIN = OSR_WIDTH'(CHANNELS - 1);
    localparam logic [CH_WIDTH-1:0]  c_CH_LAST = CH_WIDTH'(CHANNELS - 1);
    localparam logic [RES_WIDTH-1:0] c_RES_MAX = {1'b0, {(RES_WIDTH-1){1'b1}}};
    localparam logic [RES_WIDTH-1:0] c_RES_MIN = {1'b1, {(RES_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [OSR_WIDTH-1:0]   r_cnt;
    logic [OSR_WIDTH-1:0]   r_osr_eff;
    logic [1:0]             r_order_eff;
    logic [1:0]             r_burst_order;
    logic                   r_burst_ok;
    logic [1:0]             r_warm;
    logic [CH_WIDTH-1:0]    r_seq_ch;

    logic [WIDTH-1:0]       w_shadow [CHANNELS];
    logic [WIDTH-1:0]       r_xd     [CHANNELS];
    logic [WIDTH-1:0]       r_c1d    [CHANNELS];
    logic [WIDTH-1:0]       r_c2d    [CHANNELS];

    logic                   w_hit;
    logic [OSR_WIDTH-1:0]   w_osr_in;
    logic [1:0]             w_order_in;
    logic                   w_cfg_change;
    logic                   w_visit;
    logic                   w_last;
    logic [WIDTH-1:0]       w_x;
    logic [WIDTH-1:0]       w_c1;
    logic [WIDTH-1:0]       w_c2;
    logic [WIDTH-1:0]       w_c3;
    logic [WIDTH-1:0]       w_res;
    logic                   w_ovf;
    logic [RES_WIDTH-1:0]   w_sat;

    logic signed [RES_WIDTH-1:0] r_data;
    logic [CH_WIDTH-1:0]    r_ch;
    logic                   r_ovf;
    logic                   r_valid;

    assign w_hit        = (r_cnt == r_osr_eff);
    assign w_osr_in     = (i_osr < c_OSR_MIN) ? c_OSR_MIN : i_osr;
    assign w_order_in   = (i_order == 2'd0) ? 2'd3 : i_order;
    assign w_cfg_change = (w_osr_in != r_osr_eff) || (w_order_in != r_order_eff);

    // The burst launched by a hit closes the frame that just ended, so it
    // inherits the pre-latch order and the pre-decrement warm-up state.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_cnt         <= '0;
            r_osr_eff     <= '0;
            r_order_eff   <= 2'd3;
            r_burst_order <= 2'd3;
            r_burst_ok    <= 1'b0;
            r_warm        <= 2'd3;
        end else if (w_hit) begin
            r_cnt         <= '0;
            r_osr_eff     <= w_osr_in;
            r_order_eff   <= w_order_in;
            r_burst_order <= r_order_eff;
            r_burst_ok    <= (r_warm == 2'd0);
            if (w_cfg_change)
                r_warm <= 2'd3;
            else if (r_warm != 2'd0)
                r_warm <= r_warm - 2'd1;
        end else begin
            r_cnt <= r_cnt + OSR_WIDTH'(1);
        end
    end

    generate
        for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
            logic [WIDTH-1:0] w_d;
            logic [WIDTH-1:0] r_i1;
            logic [WIDTH-1:0] r_i2;
            logic [WIDTH-1:0] r_i3;
            logic [WIDTH-1:0] r_shadow;

            assign w_d         = i_sdi[n] ? WIDTH'(1) : {WIDTH{1'b1}};
            assign w_shadow[n] = r_shadow;

            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    r_i1     <= '0;
                    r_i2     <= '0;
                    r_i3     <= '0;
                    r_shadow <= '0;
                end else begin
                    r_i1 <= r_i1 + w_d;
                    r_i2 <= r_i2 + r_i1;
                    r_i3 <= r_i3 + r_i2;
                    if (w_hit) begin
                        case (r_order_eff)
                            2'd1:    r_shadow <= r_i1;
                            2'd2:    r_shadow <= r_i2;
                            default: r_shadow <= r_i3;
                        endcase
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    assign w_last = (r_seq_ch == c_CH_LAST);

    always_comb begin
        w_state_next = r_state;
        w_visit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hit)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                w_visit = 1'b1;
                if (w_last && !w_hit)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr)
            r_seq_ch <= '0;
        else if (w_visit)
            r_seq_ch <= w_last ? '0 : r_seq_ch + CH_WIDTH'(1);
    end

    assign w_x  = w_shadow[r_seq_ch];
    assign w_c1 = w_x  - r_xd[r_seq_ch];
    assign w_c2 = w_c1 - r_c1d[r_seq_ch];
    assign w_c3 = w_c2 - r_c2d[r_seq_ch];

    always_comb begin
        w_res = w_c3;
        case (r_burst_order)
            2'd1:    w_res = w_c1;
            2'd2:    w_res = w_c2;
            default: w_res = w_c3;
        endcase
    end

    // One guard bit above the result: disagreeing top bits mean out of range.
    assign w_ovf = w_res[WIDTH-1] ^ w_res[WIDTH-2];
    assign w_sat = w_ovf ? (w_res[WIDTH-1] ? c_RES_MIN : c_RES_MAX)
                         : w_res[RES_WIDTH-1:0];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_xd[n]  <= '0;
                r_c1d[n] <= '0;
                r_c2d[n] <= '0;
            end
        end else if (w_visit) begin
            r_xd[r_seq_ch]  <= w_x;
            r_c1d[r_seq_ch] <= w_c1;
            r_c2d[r_seq_ch] <= w_c2;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_visit & r_burst_ok;
            if (w_visit && r_burst_ok) begin
                r_data <= w_sat;
                r_ch   <= r_seq_ch;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign o_data  = r_data;
    assign o_ch    = r_ch;
    assign o_ovf   = r_ovf;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sincn_decim_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sincn_decim_mc
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sincn_decim_mc;

    localparam int CH = 4;
    localparam int OW = 8;
    localparam int RW = 1 + 3*OW;
    localparam int W  = RW + 1;

    logic                 clock = 1'b0;
    logic                 aclr  = 1'b1;
    logic [CH-1:0]        sdi   = '0;
    logic [OW-1:0]        osr   = '0;
    logic [1:0]           order = 2'd3;
    logic signed [RW-1:0] data;
    logic [1:0]           ch;
    logic                 ovf;
    logic                 valid;

    sincn_decim_mc #(.CHANNELS(CH), .OSR_WIDTH(OW)) dut (
        .clock   (clock),
        .aclr    (aclr),
        .i_sdi   (sdi),
        .i_osr   (osr),
        .i_order (order),
        .o_data  (data),
        .o_ch    (ch),
        .o_ovf   (ovf),
        .o_valid (valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_i1 [CH];
    longint m_i2 [CH];
    longint m_i3 [CH];
    longint m_xd [CH];
    longint m_c1d[CH];
    longint m_c2d[CH];
    longint m_cnt, m_osr_eff, m_ord_eff, m_wu;
    int     mc;
    int     gcyc = 0;
    bit     exp_v [int];
    longint exp_d [int];
    int     exp_c [int];
    bit     exp_o [int];
    int     m_mode[CH];
    bit     alt = 1'b0;

    function automatic longint wrapw(input longint v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return longint'($signed(t));
    endfunction

    task automatic model_reset();
        for (int n = 0; n < CH; n++) begin
            m_i1[n] = 0; m_i2[n] = 0; m_i3[n] = 0;
            m_xd[n] = 0; m_c1d[n] = 0; m_c2d[n] = 0;
        end
        m_cnt = 0; m_osr_eff = 0; m_ord_eff = 3; m_wu = 3; mc = 0;
        exp_v.delete(); exp_d.delete(); exp_c.delete(); exp_o.delete();
    endtask

    // One clock edge: frame bookkeeping, whole-burst comb, then integration.
    task automatic model_step();
        longint x, c1, c2, c3, r, new_osr, new_ord, vmax, vmin;
        bit o;
        vmax = (longint'(1) <<< (RW-1)) - 1;
        vmin = -(longint'(1) <<< (RW-1));
        if (m_cnt == m_osr_eff) begin
            for (int n = 0; n < CH; n++) begin
                x  = wrapw((m_ord_eff == 1) ? m_i1[n] : (m_ord_eff == 2) ? m_i2[n] : m_i3[n]);
                c1 = wrapw(x - m_xd[n]);
                c2 = wrapw(c1 - m_c1d[n]);
                c3 = wrapw(c2 - m_c2d[n]);
                m_xd[n] = x; m_c1d[n] = c1; m_c2d[n] = c2;
                r = (m_ord_eff == 1) ? c1 : (m_ord_eff == 2) ? c2 : c3;
                o = (r > vmax) || (r < vmin);
                if (r > vmax) r = vmax;
                if (r < vmin) r = vmin;
                if (m_wu == 0) begin
                    exp_v[mc+2+n] = 1'b1;
                    exp_d[mc+2+n] = r;
                    exp_c[mc+2+n] = n;
                    exp_o[mc+2+n] = o;
                end
            end
            new_osr = (longint'(osr) < CH-1) ? CH-1 : longint'(osr);
            new_ord = (order == 2'd0) ? 3 : longint'(order);
            if (new_osr != m_osr_eff || new_ord != m_ord_eff) m_wu = 3;
            else if (m_wu > 0) m_wu = m_wu - 1;
            m_osr_eff = new_osr;
            m_ord_eff = new_ord;
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        for (int n = 0; n < CH; n++) begin
            m_i3[n] = m_i3[n] + m_i2[n];
            m_i2[n] = m_i2[n] + m_i1[n];
            m_i1[n] = m_i1[n] + (sdi[n] ? 1 : -1);
        end
        mc++;
    endtask

    task automatic tick();
        bit ev;
        @(negedge clock);
        for (int n = 0; n < CH; n++) begin
            case (m_mode[n])
                0:       sdi[n] = 1'b0;
                1:       sdi[n] = 1'b1;
                2:       sdi[n] = alt;
                default: sdi[n] = 1'($urandom);
            endcase
        end
        alt = ~alt;
        model_step();
        @(posedge clock);
        #1;
        gcyc++;
        ev = exp_v.exists(mc);
        chk("model_valid", valid, ev);
        if (ev) begin
            chk("model_data", data, exp_d[mc]);
            chk("model_ch",   ch,   exp_c[mc]);
            chk("model_ovf",  ovf,  exp_o[mc]);
        end
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        repeat (3) begin
            @(negedge clock);
            sdi = CH'($urandom);
        end
        #1;
        chk("rst_data",  data,  0);
        chk("rst_ch",    ch,    0);
        chk("rst_ovf",   ovf,   0);
        chk("rst_valid", valid, 0);
        @(posedge clock);
        #2;
        aclr = 1'b0;
        model_reset();
    endtask

    task automatic next_burst(output int cyc, output longint d);
        cyc = -1;
        d   = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (valid && ch == 2'd0) begin
                cyc = gcyc;
                d   = longint'(data);
                return;
            end
        end
        chk("burst_timeout", 0, 1);
    endtask

    task automatic set_modes(input int a, input int b, input int c, input int d);
        m_mode[0] = a; m_mode[1] = b; m_mode[2] = c; m_mode[3] = d;
    endtask

    // Change order, expect: one more old burst, 3 suppressed frames, new value.
    task automatic order_step(input logic [1:0] new_order, input longint old_v,
                              input longint new_v, inout int prev);
        int     c;
        longint d;
        order = new_order;
        for (int k = 0; k < 8; k++) begin
            next_burst(c, d);
            if (c < 0 || d != old_v) break;
            prev = c;
        end
        chk("order_new_value", d, new_v);
        chk("order_gap", c - prev, 4*10);
        prev = c;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]       osr;
        logic [1:0]       order;
        logic [3:0][1:0]  mode;
        logic [3:0][31:0] exp;
        logic [3:0]       ovf;
    } vec_t;

    vec_t tbl[7];

    function automatic vec_t mk(input int o, input int od,
                                input int m0, input int m1, input int m2, input int m3,
                                input int e0, input int e1, input int e2, input int e3,
                                input bit v0, input bit v1, input bit v2, input bit v3);
        vec_t v;
        v.osr = 8'(o); v.order = 2'(od);
        v.mode[0] = 2'(m0); v.mode[1] = 2'(m1); v.mode[2] = 2'(m2); v.mode[3] = 2'(m3);
        v.exp[0] = 32'(e0); v.exp[1] = 32'(e1); v.exp[2] = 32'(e2); v.exp[3] = 32'(e3);
        v.ovf[0] = v0; v.ovf[1] = v1; v.ovf[2] = v2; v.ovf[3] = v3;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int     c, prev, nv, lim, e;
        longint d;

        tbl[0] = mk( 15, 3, 1, 0, 2, 1,     4096,    -4096,        0,     4096, 0, 0, 0, 0);
        tbl[1] = mk(255, 3, 1, 0, 1, 0, 16777215, -16777216, 16777215, -16777216, 1, 0, 1, 0);
        tbl[2] = mk(  9, 1, 1, 1, 1, 1,       10,       10,       10,       10, 0, 0, 0, 0);
        tbl[3] = mk(  9, 2, 1, 1, 1, 1,      100,      100,      100,      100, 0, 0, 0, 0);
        tbl[4] = mk(  9, 3, 1, 1, 1, 1,     1000,     1000,     1000,     1000, 0, 0, 0, 0);
        tbl[5] = mk(  9, 0, 0, 1, 0, 1,    -1000,     1000,    -1000,     1000, 0, 0, 0, 0);
        tbl[6] = mk(  1, 3, 1, 0, 1, 0,       64,      -64,       64,      -64, 0, 0, 0, 0);

        set_modes(3, 3, 3, 3);
        for (int i = 0; i < 7; i++) begin
            osr   = tbl[i].osr;
            order = tbl[i].order;
            for (int n = 0; n < CH; n++) m_mode[n] = int'(tbl[i].mode[n]);
            do_reset();
            nv  = 0;
            lim = 12*(int'(tbl[i].osr) + 1) + 100;
            for (int t = 0; t < lim && nv < 2*CH; t++) begin
                tick();
                if (valid) begin
                    chk($sformatf("tbl%0d_ch", i),   ch, nv % CH);
                    chk($sformatf("tbl%0d_data", i), data, longint'($signed(tbl[i].exp[ch])));
                    chk($sformatf("tbl%0d_ovf", i),  ovf, tbl[i].ovf[ch]);
                    nv++;
                end
            end
            chk($sformatf("tbl%0d_count", i), nv, 2*CH);
        end

        // Order changes at osr=9 with all-ones input.
        osr = 8'd9; order = 2'd1; set_modes(1, 1, 1, 1);
        do_reset();
        next_burst(c, d);
        chk("ord1_value", d, 10);
        prev = c;
        next_burst(c, d);
        chk("ord1_gap", c - prev, 10);
        prev = c;
        order_step(2'd2, 10, 100, prev);
        order_step(2'd3, 100, 1000, prev);
        order = 2'd0;
        next_burst(c, d);
        chk("ord0_value", d, 1000);
        chk("ord0_gap", c - prev, 10);

        // Back-to-back bursts: osr below the channel count.
        osr = 8'd1; order = 2'd3; set_modes(1, 1, 1, 1);
        do_reset();
        next_burst(c, d);
        chk("b2b_first", d, 64);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("b2b_valid", valid, 1);
            chk("b2b_ch", ch, i % CH);
            chk("b2b_data", data, 64);
        end

        // Reset asserted mid-burst.
        osr = 8'd15; order = 2'd3; set_modes(1, 0, 2, 1);
        do_reset();
        next_burst(c, d);
        tick();
        chk("mid_ch", ch, 1);
        #1 aclr = 1'b1;
        #1;
        chk("mid_valid", valid, 0);
        chk("mid_data", data, 0);
        chk("mid_ch_clr", ch, 0);
        do_reset();
        e = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            e++;
            if (valid) break;
        end
        chk("mid_rewarm_seen", valid, 1);
        chk("mid_no_early_valid", (e >= 3*16 + 2) ? 1 : 0, 1);

        // Randomised inputs and settings against the model.
        set_modes(3, 3, 3, 3);
        osr = 8'($urandom_range(0, 12)); order = 2'($urandom_range(0, 3));
        do_reset();
        for (int s = 0; s < 10; s++) begin
            osr   = 8'($urandom_range(0, 12));
            order = 2'($urandom_range(0, 3));
            repeat (150) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sincn_decim_mc.md
# sincn_decim_mc

Multi-channel, order-selectable sinc decimation filter for sigma-delta ADC bitstreams. This is the successor to the single-channel sinc3 decimator. It runs one CIC integrator chain per channel at the modulator clock rate. One comb section, time-multiplexed across channels, serves them all at the output rate. Output is saturating, with an overload flag and suppression of warm-up samples. It sits between the modulator input pins and the per-channel measurement logic.

## Interface
- CHANNELS, 4: number of modulator inputs; 1..16.
- OSR_WIDTH, 8: counter width; max OSR = 2**OSR_WIDTH.
- RES_WIDTH, 1+3*OSR_WIDTH: signed result width.
- WIDTH, RES_WIDTH+1: internal integrator/comb width.
- CH_WIDTH, max(1, clog2(CHANNELS)): channel index width.
- clock  in  1  modulator clock; all logic on rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- sdi  in  CHANNELS  modulator bits; bit n = channel n; 1 → +1, 0 → −1.
- osr  in  OSR_WIDTH  OSR minus 1.
- order  in  2  1 = sinc1, 2 = sinc2, 3 = sinc3, 0 = sinc3.
- data  out  RES_WIDTH  signed filtered sample.
- ch  out  CH_WIDTH  channel of current data.
- ovf  out  1  data was clamped; qualified by valid.
- valid  out  1  one-cycle strobe per channel sample.

## Operation
- Per channel: three WIDTH-bit integrators i1 += d, i2 += i1, i3 += i2.
  - Update every clock.
  - Two's-complement wrap is intended; no saturation inside the integrators.
- Decimation counter cnt: 0..osr_eff. hit = (cnt == osr_eff). On hit, cnt → 0.
- osr_eff = max(osr, CHANNELS−1).
- osr_eff and order_eff are latched on hit only. A change on osr/order takes effect at the next frame boundary.
- Snapshot: on hit, each channel's selected integrator is copied into a shadow register.
  - order_eff 1 selects i1, 2 selects i2, 3 selects i3.
- Comb sequencer: starts the cycle after hit and visits channels 0..CHANNELS−1, one per cycle.
  - Per channel keeps x_d, c1_d, c2_d histories.
  - c1 = x − x_d; c2 = c1 − c1_d; c3 = c2 − c2_d. All histories update on every visit, whatever the order.
  - Result = c1, c2 or c3 per order_eff.
- Gain = (osr_eff+1)^order. All-ones input gives +gain; all-zeros gives −gain.
- Saturation range [−2^(RES_WIDTH−1), 2^(RES_WIDTH−1)−1].
  - A result outside the range is clamped and ovf=1 for that sample. Otherwise ovf=0.
- Warm-up: a 2-bit frame counter starts at 3 on reset, and is reloaded to 3 whenever the latched osr_eff or order_eff changes value.
  - Frames processed while the counter is non-zero produce no valid. Their comb histories still update.
  - The counter decrements once per frame.

## Timing
- Reset (async, immediate): data=0, ch=0, ovf=0, valid=0. Integrators, histories, shadows, cnt and osr_eff all clear to 0. order_eff=3. Warm-up=3.
- If hit is high in cycle k:
  - The snapshot is captured at the end of cycle k.
  - Channel n is computed in cycle k+1+n.
  - data/ch/ovf/valid are registered and visible in cycle k+2+n.
- valid is high in cycles k+2..k+CHANNELS+1, with ch incrementing 0..CHANNELS−1.
- Between bursts, data holds its last value and valid=0.
- osr_eff ≥ CHANNELS−1 guarantees a shadow is never overwritten before it is read. Bursts may be back-to-back when osr_eff = CHANNELS−1.
- The first valid burst after reset is in frame 4, i.e. after the 4th hit.
- aclr asserted mid-burst: valid drops in the same cycle; the remaining channels of that burst are lost.

## Test plan
- Reset: hold aclr with random sdi → data=0, ch=0, ovf=0, valid=0. Release: no valid before the 4th hit.
- CHANNELS=4, OSR_WIDTH=8, osr=15, order=3. Inputs: ch0 all ones, ch1 all zeros, ch2 alternating 1/0, ch3 all ones.
  - Each burst after warm-up is 4096, −4096, 0, 4096 with ch=0..3 in consecutive cycles; ovf=0.
- osr=255, order=3. ch0 all ones gives data=16777215 with ovf=1. ch1 all zeros gives −16777216 with ovf=0.
- osr=9, all ones: order=1 → 10, order=2 → 100, order=3 → 1000. After each order change, exactly 3 suppressed frames precede the new value.
- osr=1 with CHANNELS=4: osr_eff=3; valid high in 4 consecutive cycles, repeating every 4 cycles with no gaps.
- aclr pulsed during cycle k+3 of a burst: valid=0 immediately. No further valid until 3 suppressed frames have elapsed after release.
